sys_array_feeder: RTL and testbench

- Transmit-side front end for the 4x4 systolic multiplier.
- Accepts matrix A (by rows) and matrix B (by columns) over a valid/ready load port and buffers both.
- Pulses a clear to the array, then drives the skewed a1..a4 / b1..b4 operand streams, one diagonal per clock.
- Ends with zero drain cycles and a done pulse. Replaces hand-written skew sequencing in benches and top levels.

---
 rtl/sys_array_feeder.sv | 190 +++++++++++++++++++
 tb/tb_sys_array_feeder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_feeder.sv
// Purpose : buffers a 4x4 A (rows) and B (columns), pulses arr_clr, then drives the skewed a/b diagonals.
// Latency : last beat at edge E -> arr_clr in cycle E+1 -> t=0 in E+2 -> done in E+2+7+DRAIN.
// Backpressure: in_ready is high only in LOAD; in_valid is ignored in every other state.
// Ports   : clk, rst (async, active-low); in_valid/in_ready/in_a_row/in_b_col load port;
//           arr_clr array clear; a1..a4 / b1..b4 skewed operand streams; busy, done status.
module sys_array_feeder #(
  parameter int DW    = 32,
  parameter int DRAIN = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*DW-1:0] in_a_row,
  input  logic [4*DW-1:0] in_b_col,
  output logic            arr_clr,
  output logic [DW-1:0]   a1,
  output logic [DW-1:0]   a2,
  output logic [DW-1:0]   a3,
  output logic [DW-1:0]   a4,
  output logic [DW-1:0]   b1,
  output logic [DW-1:0]   b2,
  output logic [DW-1:0]   b3,
  output logic [DW-1:0]   b4,
  output logic            busy,
  output logic            done
);

  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = (DRAIN > 0) ? DCW'(DRAIN - 1) : '0;

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             beat_q, beat_d;
  logic [2:0]             feed_q, feed_d;
  logic [DCW-1:0]         drain_q, drain_d;
  logic                   in_ready_q, in_ready_d;
  logic                   arr_clr_q, arr_clr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [3:0][DW-1:0]     a_q, a_d;
  logic [3:0][DW-1:0]     b_q, b_d;
  // a_mem[k] holds row k of A, b_mem[k] holds column k of B, as received.
  logic [3:0][4*DW-1:0]   a_mem_q, a_mem_d;
  logic [3:0][4*DW-1:0]   b_mem_q, b_mem_d;

  // Streams are registered, so they are computed for the cycle being entered.
  logic                   feed_stream;
  logic [2:0]             stream_t;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    feed_d      = feed_q;
    drain_d     = drain_q;
    in_ready_d  = 1'b0;
    arr_clr_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    a_mem_d     = a_mem_q;
    b_mem_d     = b_mem_q;
    feed_stream = 1'b0;
    stream_t    = 3'd0;
    a_d         = '0;
    b_d         = '0;

    case (state_q)
      S_LOAD: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_mem_d[beat_q] = in_a_row;
          b_mem_d[beat_q] = in_b_col;
          busy_d          = 1'b1;
          beat_d          = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d    = S_CLR;
            in_ready_d = 1'b0;
            arr_clr_d  = 1'b1;
          end
        end
      end
      S_CLR: begin
        state_d     = S_FEED;
        feed_d      = 3'd0;
        feed_stream = 1'b1;
        stream_t    = 3'd0;
      end
      S_FEED: begin
        if (feed_q == 3'd6) begin
          // feed_q stays at 6 after exit
          if (DRAIN == 0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end else begin
          feed_d      = feed_q + 3'd1;
          feed_stream = 1'b1;
          stream_t    = feed_q + 3'd1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d    = S_LOAD;
        beat_d     = 2'd0;
        in_ready_d = 1'b1;
      end
      default: begin
        state_d    = S_LOAD;
        beat_d     = 2'd0;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase

    // Diagonal t: lane i carries A[i][t-i] and B[t-i][i] while 0 <= t-i <= 3.
    if (feed_stream) begin
      for (int i = 0; i < 4; i++) begin
        if ((int'(stream_t) - i >= 0) && (int'(stream_t) - i <= 3)) begin
          a_d[i] = a_mem_q[i][(int'(stream_t) - i)*DW +: DW];
          b_d[i] = b_mem_q[i][(int'(stream_t) - i)*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LOAD;
      beat_q     <= 2'd0;
      feed_q     <= 3'd0;
      drain_q    <= '0;
      in_ready_q <= 1'b1;
      arr_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      feed_q     <= feed_d;
      drain_q    <= drain_d;
      in_ready_q <= in_ready_d;
      arr_clr_q  <= arr_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  // Matrix buffer is always fully rewritten before use, so it carries no reset.
  always_ff @(posedge clk) begin
    a_mem_q <= a_mem_d;
    b_mem_q <= b_mem_d;
  end

  assign in_ready = in_ready_q;
  assign arr_clr  = arr_clr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign a1       = a_q[0];
  assign a2       = a_q[1];
  assign a3       = a_q[2];
  assign a4       = a_q[3];
  assign b1       = b_q[0];
  assign b2       = b_q[1];
  assign b3       = b_q[2];
  assign b4       = b_q[3];

endmodule

// File: tb/tb_sys_array_feeder.sv
module tb_sys_array_feeder;
  localparam int DW    = 32;
  localparam int DRAIN = 6;

  typedef struct packed {
    logic               clr;
    logic               done;
    logic               busy;
    logic               rdy;
    logic [3:0][DW-1:0] a;
    logic [3:0][DW-1:0] b;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4*DW-1:0] in_a_row = '0;
  logic [4*DW-1:0] in_b_col = '0;
  logic            arr_clr, busy, done;
  logic [DW-1:0]   a1, a2, a3, a4, b1, b2, b3, b4;

  // second instance built with DRAIN=0
  logic            d_valid = 1'b0;
  logic            d_ready;
  logic [4*DW-1:0] d_a_row = '0;
  logic [4*DW-1:0] d_b_col = '0;
  logic            d_clr, d_busy, d_done;
  logic [DW-1:0]   d_a1, d_a2, d_a3, d_a4, d_b1, d_b2, d_b3, d_b4;

  sys_array_feeder #(.DW(DW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a_row(in_a_row), .in_b_col(in_b_col), .arr_clr(arr_clr),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .busy(busy), .done(done)
  );

  sys_array_feeder #(.DW(DW), .DRAIN(0)) dut_d0 (
    .clk(clk), .rst(rst), .in_valid(d_valid), .in_ready(d_ready),
    .in_a_row(d_a_row), .in_b_col(d_b_col), .arr_clr(d_clr),
    .a1(d_a1), .a2(d_a2), .a3(d_a3), .a4(d_a4), .b1(d_b1), .b2(d_b2), .b3(d_b3), .b4(d_b4),
    .busy(d_busy), .done(d_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [4*DW-1:0] act, input logic [4*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus matrices: sA[k] = row k of A, sBc[k] = column k of B.
  logic [DW-1:0] sA[4][4];
  logic [DW-1:0] sBc[4][4];

  // Reference model: captured matrix, beats seen, expected per-cycle frames.
  logic [DW-1:0] mA[4][4];
  logic [DW-1:0] mB[4][4];
  int            mbeats = 0;
  frame_t        exp_q[$];

  task automatic push_frames();
    frame_t e;
    e = '0; e.clr = 1'b1; e.busy = 1'b1;
    exp_q.push_back(e);
    for (int t = 0; t < 7; t++) begin
      e = '0; e.busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (t - i >= 0 && t - i <= 3) begin
          e.a[i] = mA[i][t-i];
          e.b[i] = mB[t-i][i];
        end
      end
      exp_q.push_back(e);
    end
    for (int d = 0; d < DRAIN; d++) begin
      e = '0; e.busy = 1'b1;
      exp_q.push_back(e);
    end
    e = '0; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every cycle, then record any handshake due at the next edge.
  always @(negedge clk) begin
    frame_t e;
    frame_t got;
    got.clr  = arr_clr;
    got.done = done;
    got.busy = busy;
    got.rdy  = in_ready;
    got.a    = {a4, a3, a2, a1};
    got.b    = {b4, b3, b2, b1};
    if (!rst) begin
      exp_q.delete();
      mbeats = 0;
      e = '0; e.rdy = 1'b1;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = '0; e.rdy = 1'b1; e.busy = (mbeats > 0);
    end
    chk("arr_clr", got.clr, e.clr);
    chk("done", got.done, e.done);
    chk("busy", got.busy, e.busy);
    chk("in_ready", got.rdy, e.rdy);
    chk("a_streams", got.a, e.a);
    chk("b_streams", got.b, e.b);
    if (rst && in_valid && in_ready) begin
      for (int j = 0; j < 4; j++) begin
        mA[mbeats][j] = in_a_row[j*DW +: DW];
        mB[j][mbeats] = in_b_col[j*DW +: DW];
      end
      mbeats++;
      if (mbeats == 4) begin
        push_frames();
        mbeats = 0;
      end
    end
  end

  task automatic set_nominal();
    sA[0] = '{1, 3, 7, 13};   sA[1] = '{4, 8, 14, 21};
    sA[2] = '{9, 15, 22, 27}; sA[3] = '{16, 23, 28, 31};
    sBc[0] = '{2, 5, 10, 17};  sBc[1] = '{6, 11, 18, 24};
    sBc[2] = '{12, 19, 25, 29}; sBc[3] = '{20, 26, 30, 32};
  endtask

  task automatic set_random();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) begin
        sA[k][j]  = $urandom();
        sBc[k][j] = $urandom();
      end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input int k, input int gap);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    for (int j = 0; j < 4; j++) begin
      in_a_row[j*DW +: DW] = sA[k][j];
      in_b_col[j*DW +: DW] = sBc[k][j];
    end
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 1'b1, 1'b0);
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_matrix(input int g0, input int g1, input int g2, input int g3);
    send_beat(0, g0);
    send_beat(1, g1);
    send_beat(2, g2);
    send_beat(3, g3);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk); n++;
    end
    if (n >= 200) chk("idle_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int clr_off, done_off, rdy_off;
    // Reset held 2 cycles with in_valid high.
    in_valid = 1'b1;
    set_random();
    for (int j = 0; j < 4; j++) begin
      in_a_row[j*DW +: DW] = sA[0][j];
      in_b_col[j*DW +: DW] = sBc[0][j];
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_streams", {a1, a2, a3, a4}, '0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Nominal back-to-back load.
    set_nominal();
    send_matrix(0, 0, 0, 0);
    in_valid = 1'b0;
    wait_idle();

    // Gapped load: valid pattern 1,0,0,1,0,1,1.
    send_matrix(0, 2, 1, 0);
    in_valid = 1'b0;
    wait_idle();

    // in_valid held high across two matrices.
    set_random();
    send_matrix(0, 0, 0, 0);
    set_random();
    send_matrix(0, 0, 0, 0);
    in_valid = 1'b0;
    wait_idle();

    // Reset asserted during t=3 of the feed.
    set_random();
    send_matrix(0, 0, 0, 0);
    in_valid = 1'b0;
    n = 0;
    while (!arr_clr && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("clr_timeout", 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_a", {a1, a2, a3, a4}, '0);
    chk("midrst_b", {b1, b2, b3, b4}, '0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    set_random();
    send_matrix(0, 0, 0, 0);
    in_valid = 1'b0;
    wait_idle();

    // Randomised loads with random gaps.
    for (int m = 0; m < 5; m++) begin
      set_random();
      send_matrix($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    wait_idle();

    // DRAIN=0 build: done right after t=6, next load the cycle after.
    set_nominal();
    d_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        d_a_row[j*DW +: DW] = sA[k][j];
        d_b_col[j*DW +: DW] = sBc[k][j];
      end
      @(negedge clk);
      chk("d0_load_ready", d_ready, 1'b1);
      @(posedge clk); #1;
    end
    for (int j = 0; j < 4; j++) begin
      d_a_row[j*DW +: DW] = sA[0][j];
      d_b_col[j*DW +: DW] = sBc[0][j];
    end
    clr_off = -1; done_off = -1; rdy_off = -1;
    for (int off = 1; off <= 12; off++) begin
      @(negedge clk);
      if (d_clr && clr_off < 0) clr_off = off;
      if (d_done && done_off < 0) done_off = off;
      if (d_ready && rdy_off < 0) rdy_off = off;
      if (off == 8) begin
        chk("d0_t6_a", {d_a1, d_a2, d_a3, d_a4}, {96'd0, 32'd31});
        chk("d0_t6_b", {d_b1, d_b2, d_b3, d_b4}, {96'd0, 32'd32});
      end
    end
    chk("d0_clr_offset", clr_off, 1);
    chk("d0_done_offset", done_off, 9);
    chk("d0_ready_offset", rdy_off, 10);
    @(posedge clk); #1;
    d_valid = 1'b0;

    @(posedge clk); #1;
    if (exp_q.size() != 0) chk("leftover_frames", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
